// File: rtl/pio_input_poller.sv
// pio_input_poller: periodic PIO sampler with debounce, change-event FIFO, CPU slave and IRQ.
// Define PIO_INPUT_POLLER_TIMESTAMP_EN to stamp events with a 12-bit free-running counter.
module pio_input_poller #(
  parameter int WIDTH      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int DEBOUNCE   = 3,
  parameter int PERIOD_RST = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0] MASK = 10'((1 << WIDTH) - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_REQ = 3'd2, S_CAP = 3'd3, S_CMP = 3'd4;

  logic [2:0]    r_state;
  logic [15:0]   r_cntdown, r_period;
  logic          r_en, r_irq_en, r_ovf;
  logic [9:0]    r_sample, r_cand, r_stable;
  logic [3:0]    r_cnt;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_fill;
  logic [11:0]   w_ts;
  logic [3:0]    w_cnt_nx;
  logic          w_same, w_push, w_pop, w_full, w_wr;
  logic [31:0]   w_event, w_rd;
  logic          w_unused;

  assign w_unused = &{1'b0, pio_readdata[31:10], s_writedata[31:16]};

`ifdef PIO_INPUT_POLLER_TIMESTAMP_EN
  logic [11:0] r_ts;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_ts <= 12'd0;
    else r_ts <= r_ts + 12'd1;
  assign w_ts = r_ts;
`else
  assign w_ts = 12'd0;
`endif

  assign pio_address = (r_state == S_REQ) ? 2'd0 : 2'd1;
  assign w_same      = r_sample == r_cand;
  assign w_cnt_nx    = w_same ? ((r_cnt == DEB) ? DEB : r_cnt + 4'd1) : 4'd1;
  // only the update that first reaches DEBOUNCE counts, saturated runs stay quiet
  assign w_push      = (r_state == S_CMP) && (w_cnt_nx == DEB) && (!w_same || r_cnt != DEB)
                       && (r_sample != r_stable);
  assign w_pop       = s_read && (s_address == 2'd1) && (r_fill != '0);
  assign w_full      = r_fill == CW'(FIFO_DEPTH);
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_event     = {w_ts, r_sample ^ r_stable, r_sample};

  always_comb begin
    w_rd = (s_address == 2'd0) ? {23'd0, 5'(r_fill), 2'b00, r_ovf, r_fill != '0} :
           (s_address == 2'd1) ? ((r_fill != '0) ? r_mem[r_rp] : 32'd0) :
           (s_address == 2'd2) ? {30'd0, r_irq_en, r_en} : {16'd0, r_period};
  end

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= w_event;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cntdown  <= 16'd0;
      r_period   <= 16'(PERIOD_RST);
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_ovf      <= 1'b0;
      r_sample   <= 10'd0;
      r_cand     <= 10'd0;
      r_stable   <= 10'd0;
      r_cnt      <= 4'd0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_fill     <= '0;
      s_readdata <= 32'd0;
      irq        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (r_en) begin
          r_state   <= S_WAIT;
          r_cntdown <= r_period;
        end
        S_WAIT: if (r_cntdown == 16'd1) r_state <= S_REQ;
                else r_cntdown <= r_cntdown - 16'd1;
        S_REQ: r_state <= S_CAP;
        S_CAP: begin
          r_sample <= pio_readdata[9:0] & MASK;
          r_state  <= S_CMP;
        end
        S_CMP: begin
          r_cand    <= r_sample;
          r_cnt     <= w_cnt_nx;
          r_cntdown <= r_period;
          r_state   <= r_en ? S_WAIT : S_IDLE;
          if (w_push) r_stable <= r_sample;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_fill <= r_fill + CW'(w_wr) - CW'(w_pop);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (s_write && s_address == 2'd0 && s_writedata[1]) r_ovf <= 1'b0;
      if (s_write && s_address == 2'd2) begin
        r_en     <= s_writedata[0];
        r_irq_en <= s_writedata[1];
      end
      if (s_write && s_address == 2'd3)
        r_period <= (s_writedata[15:0] == 16'd0) ? 16'd1 : s_writedata[15:0];
      if (s_read) s_readdata <= w_rd;
      irq <= r_irq_en & ((r_fill != '0) | r_ovf);
    end
  end
endmodule
